// File: rtl/ula_ctrl.sv
// Command/response controller that drives an external ALU, captures its result and flag,
// cross-checks it against an internal reference and keeps a saturating overflow count.
module ula_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [1:0]       ula_opcode,
  input  logic [WIDTH-1:0] ula_saida,
  input  logic             ula_flag_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic [7:0]       ovf_count,
  output logic             chk_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpSub = 2'b11;

  state_e state_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] exp_data;
  logic             exp_flag;
  logic             mismatch;

  // Reference result, computed from the registered operands the ALU is being driven with.
  always_comb begin
    sum      = ula_a + ula_b;
    diff     = ula_a - ula_b;
    exp_data = '0;
    exp_flag = 1'b0;
    case (ula_opcode)
      OpAnd: exp_data = ula_a & ula_b;
      OpOr:  exp_data = ula_a | ula_b;
      OpAdd: begin
        exp_data = sum;
        exp_flag = (ula_a[WIDTH-1] == ula_b[WIDTH-1]) && (sum[WIDTH-1] != ula_a[WIDTH-1]);
      end
      OpSub: begin
        exp_data = diff;
        exp_flag = (ula_a[WIDTH-1] != ula_b[WIDTH-1]) && (diff[WIDTH-1] != ula_a[WIDTH-1]);
      end
      default: ;
    endcase
    mismatch = (ula_saida != exp_data) || (ula_flag_o != exp_flag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ovf    <= 1'b0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_opcode <= OpAnd;
      ovf_count  <= 8'd0;
      chk_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            ula_a      <= cmd_a;
            ula_b      <= cmd_b;
            ula_opcode <= cmd_op;
            cmd_ready  <= 1'b0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          rsp_data  <= ula_saida;
          rsp_ovf   <= ula_flag_o;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
          if (ula_flag_o && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
          end
          if (mismatch) begin
            chk_err <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed bench for ula_ctrl: a behavioural external ALU, a response scoreboard
// fed by the stimulus and drained by an independent monitor.
module tb_ula_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [1:0] ula_opcode;
  logic [7:0] ula_saida;
  logic       ula_flag_o;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ovf;
  logic [7:0] ovf_count;
  logic       chk_err;

  logic       bad_alu;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  ula_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .ula_a      (ula_a),
    .ula_b      (ula_b),
    .ula_opcode (ula_opcode),
    .ula_saida  (ula_saida),
    .ula_flag_o (ula_flag_o),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .ovf_count  (ovf_count),
    .chk_err    (chk_err)
  );

  // External ALU; bad_alu makes ADD 1+1 return 0.
  logic [7:0] alu_sum;
  logic [7:0] alu_diff;
  always_comb begin
    alu_sum    = ula_a + ula_b;
    alu_diff   = ula_a - ula_b;
    ula_saida  = 8'h00;
    ula_flag_o = 1'b0;
    case (ula_opcode)
      2'b00: ula_saida = ula_a & ula_b;
      2'b01: ula_saida = ula_a | ula_b;
      2'b10: begin
        ula_saida  = alu_sum;
        ula_flag_o = (ula_a[7] == ula_b[7]) && (alu_sum[7] != ula_a[7]);
      end
      default: begin
        ula_saida  = alu_diff;
        ula_flag_o = (ula_a[7] != ula_b[7]) && (alu_diff[7] != ula_a[7]);
      end
    endcase
    if (bad_alu && ula_opcode == 2'b10 && ula_a == 8'h01 && ula_b == 8'h01) begin
      ula_saida = 8'h00;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, mon_e.data});
        check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, mon_e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of cycle k+3.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eo);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    check("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    exp_q.push_back({ed, eo});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rsp_valid_k1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rsp_valid_k2", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b1;
    bad_alu   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("reset_rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
    check("reset_ula_a", {24'd0, ula_a}, 32'd0);
    check("reset_ula_b", {24'd0, ula_b}, 32'd0);
    check("reset_ula_opcode", {30'd0, ula_opcode}, 32'd0);
    check("reset_ovf_count", {24'd0, ovf_count}, 32'd0);
    check("reset_chk_err", {31'd0, chk_err}, 32'd0);
    @(posedge clk);
    #1;

    // Basic operations
    do_op(2'b10, 8'h7F, 8'h01, 8'h80, 1'b1);
    check("add_ovf_count", {24'd0, ovf_count}, 32'd1);
    check("add_chk_err", {31'd0, chk_err}, 32'd0);
    do_op(2'b11, 8'h80, 8'h01, 8'h7F, 1'b1);
    check("sub_ovf_count", {24'd0, ovf_count}, 32'd2);
    do_op(2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);
    do_op(2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    do_op(2'b11, 8'h10, 8'h30, 8'hE0, 1'b0);
    do_op(2'b10, 8'h90, 8'h90, 8'h20, 1'b1);
    check("ula_a_held", {24'd0, ula_a}, 32'h90);
    check("ula_opcode_held", {30'd0, ula_opcode}, 32'd2);
    check("logic_chk_err", {31'd0, chk_err}, 32'd0);
    check("mix_ovf_count", {24'd0, ovf_count}, 32'd3);

    // Backpressure with a competing command held on the input
    rsp_ready = 1'b0;
    do_op(2'b10, 8'h10, 8'h20, 8'h30, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 8'h55;
    cmd_b     = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", {24'd0, rsp_data}, 32'h30);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_ula_a", {24'd0, ula_a}, 32'h10);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_idle_ula_a", {24'd0, ula_a}, 32'h10);
    exp_q.push_back({8'h44, 1'b0});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("bp_accept_ula_a", {24'd0, ula_a}, 32'h55);
    check("bp_accept_ula_opcode", {30'd0, ula_opcode}, 32'd3);
    @(negedge clk);
    check("bp_next_rsp_valid_k1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("bp_next_rsp_valid_k2", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Faulty ALU result sets a sticky error
    bad_alu = 1'b1;
    do_op(2'b10, 8'h01, 8'h01, 8'h00, 1'b0);
    check("bad_chk_err", {31'd0, chk_err}, 32'd1);
    bad_alu = 1'b0;
    do_op(2'b00, 8'h0F, 8'hFF, 8'h0F, 1'b0);
    do_op(2'b10, 8'h01, 8'h01, 8'h02, 1'b0);
    check("sticky_chk_err", {31'd0, chk_err}, 32'd1);
    pulse_reset();
    @(negedge clk);
    check("rst_chk_err", {31'd0, chk_err}, 32'd0);
    check("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    @(posedge clk);
    #1;

    // Saturation of the overflow counter
    for (int i = 0; i < 255; i++) begin
      do_op(2'b10, 8'h7F, 8'h01, 8'h80, 1'b1);
    end
    check("sat_ovf_count_255", {24'd0, ovf_count}, 32'd255);
    do_op(2'b10, 8'h7F, 8'h01, 8'h80, 1'b1);
    check("sat_ovf_count_hold", {24'd0, ovf_count}, 32'd255);

    // Reset while the command sits in ISSUE
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_a     = 8'h7F;
    cmd_b     = 8'h01;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("issue_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("issue_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("issue_rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    check("issue_rst_ula_opcode", {30'd0, ula_opcode}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("issue_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
